bnn_frame_io: RTL
=================

Name: bnn_frame_io

Overview:
- Sequential front/back end for the combinational net16 BNN top.
- Accepts an input image one row per handshake and assembles it into a held frame register that drives the network's layer_i.
- Waits a fixed settle time, then captures the class scores and performs a sequential argmax.
- Returns the winning class and its score over a valid/ready result interface.

Parameters:
- ISIZE_W, 16, image width in bits (bits per row)
- ISIZE_H, 16, image height (rows per frame)
- N_CLASS, 4, number of class scores from the network
- N_BITSCORE, 7, width of each unsigned class score
- SETTLE_CYCLES, 4, clock cycles allowed for combinational settling (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- row_valid_i  in  1  input row valid
- row_ready_o  out  1  input row ready
- row_data_i  in  ISIZE_W  row pixels, bit k -> column k
- row_last_i  in  1  marks final row (checked only with macro, see Optional Feature)
- frame_o  out  [ISIZE_H-1:0][ISIZE_W-1:0]  held frame, connects to network layer_i
- score_i  in  [N_CLASS-1:0][N_BITSCORE-1:0]  network layer_o scores
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result ready
- res_class_o  out  $clog2(N_CLASS)  winning class index
- res_score_o  out  N_BITSCORE  winning score
- busy_o  out  1  high in every state except LOAD
- err_o  out  1  sticky framing error (present only with macro)

Behaviour:
- Reset (async, rst_i=1): state=LOAD, row counter=0, frame_o=0, res_valid_o=0, res_class_o=0, res_score_o=0, busy_o=0, err_o=0. Reset asserted mid-frame/mid-scan aborts everything; no partial result is emitted.
- FSM states: LOAD, SETTLE, SCAN, OUT.
- LOAD:
  - row_ready_o=1.
  - On row_valid_i&&row_ready_o, row_data_i is written to frame_o[row counter] and the counter increments.
  - The handshake that writes row ISIZE_H-1 moves to SETTLE with the settle counter set to SETTLE_CYCLES-1; the row counter wraps to 0.
  - Rows not yet rewritten keep their previous-frame contents.
- SETTLE:
  - row_ready_o=0; frame_o is frozen.
  - The counter decrements each cycle.
  - In the cycle the counter is 0, score_i is registered into the internal score array, best_score=0, best_idx=0, scan_idx=0, and the FSM moves to SCAN.
- SCAN:
  - One class per cycle, scan_idx=0..N_CLASS-1.
  - If score[scan_idx] > best_score (unsigned, strict), best takes that score and index. Ties resolve to the lowest index; all-zero scores give class 0.
  - After scan_idx=N_CLASS-1, best_* is loaded into res_class_o/res_score_o and the FSM moves to OUT.
- OUT:
  - res_valid_o=1; res_class_o/res_score_o are stable while valid.
  - On res_valid_o&&res_ready_i: res_valid_o=0 and the FSM moves to LOAD next cycle.
  - No row is accepted in the handshake cycle.
- Latency: res_valid_o is high after SETTLE_CYCLES+N_CLASS rising edges following the edge that accepted the last row (defaults: 8). Throughput is one frame per ISIZE_H+SETTLE_CYCLES+N_CLASS+1 cycles minimum.
- row_valid_i outside LOAD is ignored (not consumed). row_data_i is don't-care when not valid.
- busy_o = (state != LOAD).

Optional Feature:
- Macro BNN_FRAME_IO_LAST_CHECK_EN.
- Defined:
  - err_o port exists.
  - In LOAD, an accepted row with row_last_i mismatching (row counter==ISIZE_H-1) sets err_o sticky until reset.
  - A row_last_i=1 that arrives early additionally resynchronises: the row counter returns to 0, the FSM stays in LOAD, and no inference is launched.
- Undefined: row_last_i is ignored, err_o is absent, and the frame closes purely on row count.

Test Plan:
- Frame rows i=0..15, row_data=16'h0001<<i; score_i={7'd3,7'd90,7'd12,7'd5} (class3..0) -> frame_o[5]=16'h0020; res_valid_o 8 edges after last row; res_class_o=2, res_score_o=90.
- Scores all 7'd0 -> res_class_o=0, res_score_o=0. Scores {7'd40,7'd40,7'd7,7'd40} -> class 0 (tie, lowest index).
- res_ready_i held 0 for 10 cycles in OUT -> res_valid_o and outputs stable, row_ready_o=0; the ready pulse completes the handshake, and row_ready_o=1 on the next cycle.
- row_valid_i toggling 1/0 every cycle during LOAD -> exactly 16 accepted rows close the frame; the row offered during SETTLE is not consumed.
- rst_i pulsed asynchronously during SCAN -> all outputs return to reset values immediately; the next full frame produces a correct result with no stale res_valid_o.
- With BNN_FRAME_IO_LAST_CHECK_EN: row_last_i=1 on row 9 -> err_o=1 and the counter resets; a subsequent correct 16-row frame completes normally with err_o still 1.

Source files
------------

// File: rtl/bnn_frame_io.sv
// bnn_frame_io: sequential front/back end for the combinational net16 BNN.
// Rows arrive one per handshake and are assembled into a held frame that
// drives the network input. After a fixed settle time the class scores are
// captured and scanned for the argmax, one class per cycle. The winning class
// and its score are returned over a valid/ready interface.
// Optional macro BNN_FRAME_IO_LAST_CHECK_EN adds row_last_i framing checks
// and the sticky err_o output.
module bnn_frame_io #(
  parameter int ISIZE_W       = 16,
  parameter int ISIZE_H       = 16,
  parameter int N_CLASS       = 4,
  parameter int N_BITSCORE    = 7,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   row_valid_i,
  output logic                                   row_ready_o,
  input  logic [ISIZE_W-1:0]                     row_data_i,
  input  logic                                   row_last_i,
  output logic [ISIZE_H-1:0][ISIZE_W-1:0]        frame_o,
  input  logic [N_CLASS-1:0][N_BITSCORE-1:0]     score_i,
  output logic                                   res_valid_o,
  input  logic                                   res_ready_i,
  output logic [$clog2(N_CLASS)-1:0]             res_class_o,
  output logic [N_BITSCORE-1:0]                  res_score_o,
  output logic                                   busy_o
`ifdef BNN_FRAME_IO_LAST_CHECK_EN
  ,
  output logic                                   err_o
`endif
);

  localparam int ROW_W = $clog2(ISIZE_H);
  localparam int CLS_W = $clog2(N_CLASS);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ISIZE_H - 1);
  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(N_CLASS - 1);
  localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  logic [1:0]       state;
  logic [ROW_W-1:0] row_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic [CLS_W-1:0] scan_idx;

  // Captured scores and running best of the scan.
  logic [N_CLASS-1:0][N_BITSCORE-1:0] score_p0;
  logic [N_BITSCORE-1:0]              best_score_p1;
  logic [CLS_W-1:0]                   best_idx_p1;

  logic [N_BITSCORE-1:0] cand;
  logic                  take;
  logic                  capture;

  // Strict unsigned compare: equal scores never displace the earlier index.
  function automatic logic is_better(input logic [N_BITSCORE-1:0] a,
                                     input logic [N_BITSCORE-1:0] b);
    return a > b;
  endfunction

  assign row_ready_o = (state == ST_LOAD);
  assign res_valid_o = (state == ST_OUT);
  assign busy_o      = (state != ST_LOAD);
  assign cand        = score_p0[scan_idx];
  assign take        = is_better(cand, best_score_p1);
  assign capture     = (state == ST_SETTLE) && (settle_cnt == '0);

  // Control FSM, frame assembly and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_LOAD;
      row_cnt     <= '0;
      settle_cnt  <= '0;
      scan_idx    <= '0;
      frame_o     <= '0;
      res_class_o <= '0;
      res_score_o <= '0;
`ifdef BNN_FRAME_IO_LAST_CHECK_EN
      err_o       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          if (row_valid_i) begin
            frame_o[row_cnt] <= row_data_i;
`ifdef BNN_FRAME_IO_LAST_CHECK_EN
            if (row_last_i != (row_cnt == ROW_LAST)) err_o <= 1'b1;
`endif
            if (row_cnt == ROW_LAST) begin
              row_cnt    <= '0;
              settle_cnt <= SET_INIT;
              state      <= ST_SETTLE;
            end
`ifdef BNN_FRAME_IO_LAST_CHECK_EN
            else if (row_last_i) begin
              // Early last marker: drop the partial frame and realign.
              row_cnt <= '0;
            end
`endif
            else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            scan_idx <= '0;
            state    <= ST_SCAN;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_SCAN: begin
          if (scan_idx == CLS_LAST) begin
            res_class_o <= take ? scan_idx : best_idx_p1;
            res_score_o <= take ? cand : best_score_p1;
            state       <= ST_OUT;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        ST_OUT: begin
          if (res_ready_i) state <= ST_LOAD;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // ---- stage p0/p1: score capture and running argmax ----
  always_ff @(posedge clk_i) begin
    if (capture) begin
      score_p0      <= score_i;
      best_score_p1 <= '0;
      best_idx_p1   <= '0;
    end else if ((state == ST_SCAN) && take) begin
      best_score_p1 <= cand;
      best_idx_p1   <= scan_idx;
    end
  end

endmodule
